// File: rtl/vehicle_pkg.sv
// Shared definitions for the vehicle dynamics block: gear codes, cruise states,
// gear-stage thresholds and the piecewise rpm curve.
package vehicle_pkg;

  localparam logic [3:0] GEAR_P = 4'd3;
  localparam logic [3:0] GEAR_R = 4'd6;
  localparam logic [3:0] GEAR_N = 4'd9;
  localparam logic [3:0] GEAR_D = 4'd12;

  typedef enum logic [1:0] {
    CC_OFF     = 2'd0,
    CC_ACTIVE  = 2'd1,
    CC_STANDBY = 2'd2
  } cc_state_t;

  // Speed at which stages 2..6 begin; below the first threshold is stage 1.
  localparam int STAGE_THR [5] = '{30, 60, 90, 130, 180};

  // rpm = base + (speed - offset) * slope, indexed by stage-1.
  localparam int RPM_BASE  [6] = '{800, 1500, 1500, 1600, 1700, 1800};
  localparam int RPM_OFS   [6] = '{0, 30, 60, 90, 130, 180};
  localparam int RPM_SLOPE [6] = '{90, 70, 50, 40, 30, 20};

  localparam int IDLE_SLOPE  = 20;
  localparam int RPM_HOT     = 3000;
  localparam int RPM_CONSUME = 1000;

  function automatic logic [2:0] stage_of(input int s);
    logic [2:0] st;
    st = 3'd1;
    for (int i = 0; i < 5; i++) begin
      if (s >= STAGE_THR[i]) st = 3'(i + 2);
    end
    return st;
  endfunction

  function automatic int rpm_of(input logic [2:0] st, input int s);
    int idx;
    idx = (st == 3'd0) ? 0 : int'(st) - 1;
    return RPM_BASE[idx] + (s - RPM_OFS[idx]) * RPM_SLOPE[idx];
  endfunction

endpackage

// File: rtl/cruise_ctrl_fsm.sv
// Cruise-control state machine: OFF / ACTIVE / STANDBY with a stored target speed.
// Engine-off and leaving D dominate; brakes and cancel only suspend.
module cruise_ctrl_fsm
  import vehicle_pkg::*;
#(
  parameter int SPEED_W = 8,
  parameter int CC_MIN  = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               engine_on,
  input  logic [3:0]         gear,
  input  logic               brake_normal,
  input  logic               brake_hard,
  input  logic               cc_set,
  input  logic               cc_cancel,
  input  logic               cc_resume,
  input  logic [SPEED_W-1:0] speed,
  output logic [1:0]         cc_state,
  output logic [SPEED_W-1:0] cc_target,
  output logic               cruise_engaged
);

  cc_state_t          state_reg, state_next;
  logic [SPEED_W-1:0] target_reg, target_next;
  logic               brake;
  logic               can_engage;

  assign brake      = brake_normal | brake_hard;
  assign can_engage = (speed >= SPEED_W'(CC_MIN)) && !brake;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= CC_OFF;
      target_reg <= '0;
    end else begin
      state_reg  <= state_next;
      target_reg <= target_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    target_next = target_reg;
    if (!engine_on || gear != GEAR_D) begin
      state_next  = CC_OFF;
      target_next = '0;
    end else if (brake) begin
      if (state_reg == CC_ACTIVE) state_next = CC_STANDBY;
    end else if (cc_cancel) begin
      if (state_reg == CC_ACTIVE) state_next = CC_STANDBY;
    end else if (cc_set) begin
      if (can_engage) begin
        state_next  = CC_ACTIVE;
        target_next = speed;
      end
    end else if (cc_resume) begin
      if (state_reg == CC_STANDBY && can_engage) state_next = CC_ACTIVE;
    end
  end

  assign cc_state       = state_reg;
  assign cc_target      = target_reg;
  assign cruise_engaged = (state_reg == CC_ACTIVE);

endmodule

// File: rtl/vehicle_dynamics_cc.sv
// Vehicle physics: speed, registered rpm, gear stage, fuel, temperature, odometer,
// emergency-stop lamp hold and cruise control.
module vehicle_dynamics_cc
  import vehicle_pkg::*;
#(
  parameter int SPEED_W     = 8,
  parameter int MAX_SPEED   = 250,
  parameter int REV_MAX     = 50,
  parameter int DEAD_ZONE   = 10,
  parameter int BRAKE_N     = 3,
  parameter int BRAKE_H     = 8,
  parameter int ESS_SPEED   = 50,
  parameter int ESS_HOLD    = 3,
  parameter int CC_MIN      = 30,
  parameter int FUEL_MAX    = 100,
  parameter int FUEL_PERIOD = 3,
  parameter int LOW_FUEL    = 10,
  parameter int TEMP_MIN    = 40,
  parameter int TEMP_MAX    = 200,
  parameter int IDLE_RPM    = 800,
  parameter int RPM_MAX     = 8000,
  parameter int ODO_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               engine_on,
  input  logic               tick_1sec,
  input  logic               tick_speed,
  input  logic [3:0]         current_gear,
  input  logic [7:0]         adc_accel,
  input  logic               is_brake_normal,
  input  logic               is_brake_hard,
  input  logic               cc_set,
  input  logic               cc_cancel,
  input  logic               cc_resume,
  output logic [SPEED_W-1:0] speed,
  output logic [13:0]        rpm,
  output logic [2:0]         gear_stage,
  output logic [7:0]         fuel,
  output logic               low_fuel,
  output logic [7:0]         temp,
  output logic [ODO_W-1:0]   odometer_raw,
  output logic               ess_active,
  output logic [1:0]         cc_state,
  output logic [SPEED_W-1:0] cc_target
);

  localparam int CW      = (SPEED_W + 1 > 8) ? SPEED_W + 1 : 8;
  localparam int ESS_CW  = $clog2(ESS_HOLD + 1);
  localparam int FUEL_CW = $clog2(FUEL_PERIOD + 1);

  logic [SPEED_W-1:0] speed_reg, speed_next;
  logic [13:0]        rpm_reg, rpm_next;
  logic [2:0]         stage_reg, stage_next, stage_now;
  logic [7:0]         fuel_reg, temp_reg;
  logic               low_fuel_reg, ess_reg;
  logic [ODO_W-1:0]   odo_reg;
  logic [ESS_CW-1:0]  ess_cnt_reg;
  logic [FUEL_CW-1:0] fuel_cnt_reg;

  logic               is_d, is_r, cruise_engaged, ess_trig, consuming;
  logic [7:0]         eff, power;
  logic [SPEED_W:0]   resistance;
  logic [CW-1:0]      power_x, resist_x;
  logic [SPEED_W-1:0] speed_cap;
  logic [8:0]         temp_up;
  int                 rpm_calc;

  assign is_d       = (current_gear == GEAR_D);
  assign is_r       = (current_gear == GEAR_R);
  assign eff        = (adc_accel > 8'(DEAD_ZONE)) ? adc_accel : 8'd0;
  assign power      = (fuel_reg == 8'd0) ? 8'd0 : is_d ? eff : is_r ? (eff >> 1) : 8'd0;
  assign resistance = ({1'b0, speed_reg} >> 2) + (SPEED_W+1)'(2);
  assign power_x    = CW'(power);
  assign resist_x   = CW'(resistance);
  assign speed_cap  = is_r ? SPEED_W'(REV_MAX) : SPEED_W'(MAX_SPEED);
  assign ess_trig   = tick_speed && is_brake_hard && (speed_reg > SPEED_W'(ESS_SPEED));
  assign consuming  = (speed_reg != '0) || (rpm_reg > 14'(RPM_CONSUME));
  assign temp_up    = {1'b0, temp_reg} + 9'd2;

  cruise_ctrl_fsm #(
    .SPEED_W (SPEED_W),
    .CC_MIN  (CC_MIN)
  ) u_cruise (
    .clk            (clk),
    .rst            (rst),
    .engine_on      (engine_on),
    .gear           (current_gear),
    .brake_normal   (is_brake_normal),
    .brake_hard     (is_brake_hard),
    .cc_set         (cc_set),
    .cc_cancel      (cc_cancel),
    .cc_resume      (cc_resume),
    .speed          (speed_reg),
    .cc_state       (cc_state),
    .cc_target      (cc_target),
    .cruise_engaged (cruise_engaged)
  );

  // Brakes dominate; cruise only steers when the pedal is not already winning.
  always_comb begin
    speed_next = speed_reg;
    if (tick_speed) begin
      if (is_brake_hard) begin
        speed_next = (speed_reg > SPEED_W'(BRAKE_H)) ? speed_reg - SPEED_W'(BRAKE_H) : '0;
      end else if (is_brake_normal) begin
        speed_next = (speed_reg > SPEED_W'(BRAKE_N)) ? speed_reg - SPEED_W'(BRAKE_N) : '0;
      end else if (cruise_engaged && power_x <= resist_x) begin
        if (speed_reg < cc_target)      speed_next = speed_reg + 1'b1;
        else if (speed_reg > cc_target) speed_next = speed_reg - 1'b1;
      end else if (power_x > resist_x) begin
        if (speed_reg < speed_cap) speed_next = speed_reg + 1'b1;
      end else if (power_x < resist_x) begin
        if (speed_reg != '0) speed_next = speed_reg - 1'b1;
      end
    end
  end

  always_comb begin
    stage_now  = stage_of(int'(speed_reg));
    stage_next = 3'd0;
    rpm_calc   = IDLE_RPM + int'(eff) * IDLE_SLOPE;
    if (is_d || is_r) begin
      stage_next = stage_now;
      rpm_calc   = rpm_of(stage_now, int'(speed_reg));
    end
    rpm_next = (rpm_calc > RPM_MAX) ? 14'(RPM_MAX) : 14'(rpm_calc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      speed_reg    <= '0;
      rpm_reg      <= '0;
      stage_reg    <= '0;
      fuel_reg     <= 8'(FUEL_MAX);
      low_fuel_reg <= 1'b0;
      temp_reg     <= 8'(TEMP_MIN);
      odo_reg      <= '0;
      ess_reg      <= 1'b0;
      ess_cnt_reg  <= '0;
      fuel_cnt_reg <= '0;
    end else begin
      low_fuel_reg <= (fuel_reg <= 8'(LOW_FUEL));
      if (!engine_on) begin
        speed_reg   <= '0;
        rpm_reg     <= '0;
        stage_reg   <= '0;
        ess_reg     <= 1'b0;
        ess_cnt_reg <= '0;
      end else begin
        speed_reg <= speed_next;
        rpm_reg   <= rpm_next;
        stage_reg <= stage_next;
        if (ess_trig) begin
          ess_reg     <= 1'b1;
          ess_cnt_reg <= ESS_CW'(ESS_HOLD);
        end else if (tick_1sec && ess_cnt_reg != '0) begin
          ess_cnt_reg <= ess_cnt_reg - 1'b1;
          ess_reg     <= (ess_cnt_reg != ESS_CW'(1));
        end
        if (tick_1sec) begin
          odo_reg <= odo_reg + ODO_W'(speed_reg);
          if (consuming) begin
            if (fuel_cnt_reg == FUEL_CW'(FUEL_PERIOD - 1)) begin
              fuel_cnt_reg <= '0;
              fuel_reg     <= (fuel_reg != 8'd0) ? fuel_reg - 8'd1 : 8'd0;
            end else begin
              fuel_cnt_reg <= fuel_cnt_reg + 1'b1;
            end
          end
          if (rpm_reg > 14'(RPM_HOT))
            temp_reg <= (temp_up > 9'(TEMP_MAX)) ? 8'(TEMP_MAX) : temp_up[7:0];
          else
            temp_reg <= (temp_reg > 8'(TEMP_MIN)) ? temp_reg - 8'd1 : 8'(TEMP_MIN);
        end
      end
    end
  end

  assign speed        = speed_reg;
  assign rpm          = rpm_reg;
  assign gear_stage   = stage_reg;
  assign fuel         = fuel_reg;
  assign low_fuel     = low_fuel_reg;
  assign temp         = temp_reg;
  assign odometer_raw = odo_reg;
  assign ess_active   = ess_reg;

endmodule

// File: tb/tb_vehicle_dynamics_cc.sv
// Directed bench for vehicle_dynamics_cc: hand-computed expectations checked with
// immediate assertions, one line per check.
module tb_vehicle_dynamics_cc;

  localparam logic [3:0] G_R = 4'd6;
  localparam logic [3:0] G_N = 4'd9;
  localparam logic [3:0] G_D = 4'd12;

  logic        clk = 1'b0;
  logic        rst, engine_on, tick_1sec, tick_speed;
  logic [3:0]  current_gear;
  logic [7:0]  adc_accel;
  logic        is_brake_normal, is_brake_hard, cc_set, cc_cancel, cc_resume;
  logic [7:0]  speed;
  logic [13:0] rpm;
  logic [2:0]  gear_stage;
  logic [7:0]  fuel;
  logic        low_fuel;
  logic [7:0]  temp;
  logic [31:0] odometer_raw;
  logic        ess_active;
  logic [1:0]  cc_state;
  logic [7:0]  cc_target;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vehicle_dynamics_cc dut (
    .clk             (clk),
    .rst             (rst),
    .engine_on       (engine_on),
    .tick_1sec       (tick_1sec),
    .tick_speed      (tick_speed),
    .current_gear    (current_gear),
    .adc_accel       (adc_accel),
    .is_brake_normal (is_brake_normal),
    .is_brake_hard   (is_brake_hard),
    .cc_set          (cc_set),
    .cc_cancel       (cc_cancel),
    .cc_resume       (cc_resume),
    .speed           (speed),
    .rpm             (rpm),
    .gear_stage      (gear_stage),
    .fuel            (fuel),
    .low_fuel        (low_fuel),
    .temp            (temp),
    .odometer_raw    (odometer_raw),
    .ess_active      (ess_active),
    .cc_state        (cc_state),
    .cc_target       (cc_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) begin
      $display("check %s: observed=%0d expected=%0d ok", tag, obs, exp_v);
    end else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ts(input int n);
    repeat (n) begin
      tick_speed = 1'b1; cyc(1);
      tick_speed = 1'b0; cyc(1);
    end
  endtask

  task automatic t1(input int n);
    repeat (n) begin
      tick_1sec = 1'b1; cyc(1);
      tick_1sec = 1'b0; cyc(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc(2);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; engine_on = 1'b0; tick_1sec = 1'b0; tick_speed = 1'b0;
    current_gear = G_N; adc_accel = 8'd0;
    is_brake_normal = 1'b0; is_brake_hard = 1'b0;
    cc_set = 1'b0; cc_cancel = 1'b0; cc_resume = 1'b0;

    // Reset state
    cyc(3);
    chk("rst_speed", speed, 0);
    chk("rst_rpm", rpm, 0);
    chk("rst_stage", gear_stage, 0);
    chk("rst_fuel", fuel, 100);
    chk("rst_low_fuel", low_fuel, 0);
    chk("rst_temp", temp, 40);
    chk("rst_odo", odometer_raw, 0);
    chk("rst_ess", ess_active, 0);
    chk("rst_cc_state", cc_state, 0);
    chk("rst_cc_target", cc_target, 0);
    rst = 1'b0;

    // Accelerate in D to 40
    engine_on = 1'b1; current_gear = G_D; adc_accel = 8'd200;
    ts(40);
    chk("accel_speed", speed, 40);
    chk("accel_stage", gear_stage, 2);
    chk("accel_rpm", rpm, 2200);

    // Cruise engage and hold
    cc_set = 1'b1; cyc(1); cc_set = 1'b0; cyc(1);
    chk("cc_set_state", cc_state, 1);
    chk("cc_set_target", cc_target, 40);
    adc_accel = 8'd0;
    ts(20);
    chk("cc_hold_speed", speed, 40);
    adc_accel = 8'd200; ts(1);
    chk("override_speed", speed, 41);
    chk("override_target", cc_target, 40);
    adc_accel = 8'd0; ts(1);
    chk("override_return", speed, 40);

    // Brake suspends, resume restores
    is_brake_normal = 1'b1; ts(1); is_brake_normal = 1'b0;
    chk("brake_speed", speed, 37);
    chk("brake_state", cc_state, 2);
    chk("brake_target", cc_target, 40);
    cc_resume = 1'b1; cyc(1); cc_resume = 1'b0; cyc(1);
    chk("resume_state", cc_state, 1);
    ts(3);
    chk("resume_speed", speed, 40);
    cc_cancel = 1'b1; cyc(1); cc_cancel = 1'b0; cyc(1);
    chk("cancel_state", cc_state, 2);
    cc_set = 1'b1; cyc(1); cc_set = 1'b0; cyc(1);
    chk("reset_from_standby", cc_state, 1);
    current_gear = G_N; cyc(1);
    chk("neutral_state", cc_state, 0);
    chk("neutral_target", cc_target, 0);

    // Coast in N, dead-zone rpm, cc_set too slow, then at CC_MIN
    ts(20);
    chk("coast_speed", speed, 20);
    chk("coast_stage", gear_stage, 0);
    chk("coast_rpm", rpm, 800);
    adc_accel = 8'd10; cyc(1);
    chk("deadzone_rpm", rpm, 800);
    adc_accel = 8'd11; cyc(1);
    chk("above_deadzone_rpm", rpm, 1020);
    current_gear = G_D; adc_accel = 8'd0;
    cc_set = 1'b1; cyc(1); cc_set = 1'b0; cyc(1);
    chk("slow_set_state", cc_state, 0);
    adc_accel = 8'd200; ts(10);
    chk("ccmin_speed", speed, 30);
    cc_set = 1'b1; cyc(1); cc_set = 1'b0; cyc(1);
    chk("ccmin_state", cc_state, 1);
    chk("ccmin_target", cc_target, 30);

    // ESS trigger, hold, retrigger and threshold
    do_reset();
    ts(60);
    chk("ess_pre_speed", speed, 60);
    is_brake_hard = 1'b1; ts(1); is_brake_hard = 1'b0;
    chk("hard_speed", speed, 52);
    chk("ess_on", ess_active, 1);
    t1(2);
    chk("ess_hold2", ess_active, 1);
    t1(1);
    chk("ess_clear", ess_active, 0);
    is_brake_hard = 1'b1; ts(1); is_brake_hard = 1'b0;
    chk("ess_again", ess_active, 1);
    t1(2);
    ts(7);
    chk("ess_reaccel", speed, 51);
    is_brake_hard = 1'b1; ts(1); is_brake_hard = 1'b0;
    t1(2);
    chk("retrig_hold2", ess_active, 1);
    t1(1);
    chk("retrig_clear", ess_active, 0);
    ts(7);
    is_brake_hard = 1'b1; ts(1); is_brake_hard = 1'b0;
    chk("ess_at50_speed", speed, 42);
    chk("ess_at50_none", ess_active, 0);

    // Reverse ceiling, then D dead zone decay
    do_reset();
    current_gear = G_R; adc_accel = 8'd255;
    ts(100);
    chk("rev_speed", speed, 50);
    chk("rev_stage", gear_stage, 2);
    chk("rev_rpm", rpm, 2900);
    current_gear = G_D; adc_accel = 8'd5; ts(1);
    chk("adc5_decay", speed, 49);
    adc_accel = 8'd10; ts(1);
    chk("adc10_decay", speed, 48);

    // High rpm heats coolant
    current_gear = G_N; adc_accel = 8'd200; cyc(1);
    chk("idle_rev_rpm", rpm, 4800);
    t1(2);
    chk("temp_rise", temp, 44);

    // Odometer
    do_reset();
    current_gear = G_D; adc_accel = 8'd200;
    ts(100);
    chk("odo_pre_speed", speed, 100);
    t1(5);
    chk("odo_500", odometer_raw, 500);
    chk("odo_fuel", fuel, 99);
    chk("odo_temp", temp, 40);

    // Fuel drain, low-fuel threshold, starvation
    do_reset();
    ts(10);
    t1(267);
    chk("fuel_11", fuel, 11);
    chk("low_fuel_11", low_fuel, 0);
    t1(3);
    chk("fuel_10", fuel, 10);
    chk("low_fuel_10", low_fuel, 1);
    t1(30);
    chk("fuel_0", fuel, 0);
    t1(3);
    chk("fuel_sat", fuel, 0);
    chk("low_fuel_0", low_fuel, 1);
    ts(1);
    chk("starve_decay", speed, 9);
    chk("fuel_odo", odometer_raw, 3030);

    // Engine off
    engine_on = 1'b0; cyc(1);
    chk("off_speed", speed, 0);
    chk("off_rpm", rpm, 0);
    chk("off_stage", gear_stage, 0);
    chk("off_cc_state", cc_state, 0);
    chk("off_odo_hold", odometer_raw, 3030);
    chk("off_temp_hold", temp, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
